// File: rtl/hazard_sequencer_if.sv
// Pipeline-control bundle between the hazard sequencer and the ID/EX/MEM stages.
// Carries hazard sources in and stall/flush/bubble controls plus status counters out.
interface hazard_sequencer_if;
    logic [4:0]  id_rs1_I;
    logic [4:0]  id_rs2_I;
    logic        id_useRs1_I;
    logic        id_useRs2_I;
    logic [4:0]  ex_rd_I;
    logic        ex_memRead_I;
    logic        ex_redirect_I;
    logic        dmem_req_I;
    logic        dmem_ready_I;
    logic        pcStall_O;
    logic        ifidStall_O;
    logic        idexStall_O;
    logic        exmemStall_O;
    logic        ifidFlush_O;
    logic        idexFlush_O;
    logic        memwbBubble_O;
    logic        busErr_O;
    logic [15:0] stallCycles_O;
    logic [7:0]  flushCount_O;

    modport slave (
        input  id_rs1_I, id_rs2_I, id_useRs1_I, id_useRs2_I, ex_rd_I, ex_memRead_I,
               ex_redirect_I, dmem_req_I, dmem_ready_I,
        output pcStall_O, ifidStall_O, idexStall_O, exmemStall_O, ifidFlush_O,
               idexFlush_O, memwbBubble_O, busErr_O, stallCycles_O, flushCount_O
    );

    modport master (
        output id_rs1_I, id_rs2_I, id_useRs1_I, id_useRs2_I, ex_rd_I, ex_memRead_I,
               ex_redirect_I, dmem_req_I, dmem_ready_I,
        input  pcStall_O, ifidStall_O, idexStall_O, exmemStall_O, ifidFlush_O,
               idexFlush_O, memwbBubble_O, busErr_O, stallCycles_O, flushCount_O
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: memory-wait freeze with timeout, redirect flush, load-use stall.
// Zero-latency combinational controls; a data-memory wait freezes the whole pipeline.
module hazard_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_I,
    input  logic              reset_n_I,
    hazard_sequencer_if.slave hs
);
    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  waitCnt_q, waitCnt_d;
    logic        pendRedir_q, pendRedir_d;
    logic        busErr_q, busErr_d;
    logic [15:0] stallCycles_q, stallCycles_d;
    logic [7:0]  flushCount_q, flushCount_d;

    logic toFire, memHold, flush, loadUse, luApply, pcStall;

    assign toFire  = (state_q == MEM_WAIT) && (waitCnt_q == LAST_WAIT);
    assign memHold = hs.dmem_req_I && !hs.dmem_ready_I && !toFire;
    // A redirect seen while frozen is held in pendRedir and issued once on release.
    assign flush   = !memHold && (hs.ex_redirect_I || pendRedir_q);
    assign loadUse = hs.ex_memRead_I && (hs.ex_rd_I != 5'd0) &&
                     ((hs.id_useRs1_I && (hs.ex_rd_I == hs.id_rs1_I)) ||
                      (hs.id_useRs2_I && (hs.ex_rd_I == hs.id_rs2_I)));
    assign luApply = loadUse && !memHold && !toFire && !flush;
    assign pcStall = memHold || luApply;

    always_ff @(posedge clk_I or negedge reset_n_I) begin
        if (!reset_n_I) state_q <= RUN;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (memHold) state_d = MEM_WAIT;
            MEM_WAIT: if (hs.dmem_ready_I || toFire) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        hs.pcStall_O     = pcStall;
        hs.ifidStall_O   = pcStall;
        hs.idexStall_O   = memHold;
        hs.exmemStall_O  = memHold;
        hs.ifidFlush_O   = flush;
        hs.idexFlush_O   = flush || luApply;
        hs.memwbBubble_O = memHold || toFire;
    end

    always_comb begin
        waitCnt_d   = (state_q == MEM_WAIT) ? waitCnt_q + 8'd1 : 8'd0;
        pendRedir_d = pendRedir_q;
        if (flush)
            pendRedir_d = 1'b0;
        else if (hs.ex_redirect_I && memHold)
            pendRedir_d = 1'b1;
        busErr_d      = busErr_q || toFire;
        stallCycles_d = stallCycles_q;
        if (pcStall && (stallCycles_q != 16'hFFFF))
            stallCycles_d = stallCycles_q + 16'd1;
        flushCount_d  = flushCount_q;
        if (flush && (flushCount_q != 8'hFF))
            flushCount_d = flushCount_q + 8'd1;
    end

    always_ff @(posedge clk_I or negedge reset_n_I) begin
        if (!reset_n_I) begin
            waitCnt_q     <= 8'd0;
            pendRedir_q   <= 1'b0;
            busErr_q      <= 1'b0;
            stallCycles_q <= 16'd0;
            flushCount_q  <= 8'd0;
        end else begin
            waitCnt_q     <= waitCnt_d;
            pendRedir_q   <= pendRedir_d;
            busErr_q      <= busErr_d;
            stallCycles_q <= stallCycles_d;
            flushCount_q  <= flushCount_d;
        end
    end

    assign hs.busErr_O      = busErr_q;
    assign hs.stallCycles_O = stallCycles_q;
    assign hs.flushCount_O  = flushCount_q;
endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: vector table for the combinational controls plus
// hand-written freeze, timeout, reset and saturation sequences.
module tb_hazard_sequencer;
    localparam int unsigned TO = 4;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t        i;
        logic [6:0] e;
        string      nm;
    } vec_t;

    typedef struct {
        logic [6:0] e;
        string      nm;
    } sb_t;

    // {pcStall, ifidStall, idexStall, exmemStall, ifidFlush, idexFlush, memwbBubble}
    localparam logic [6:0] O_IDLE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100010;
    localparam logic [6:0] O_FRZ  = 7'b1111001;
    localparam logic [6:0] O_FL   = 7'b0000110;
    localparam logic [6:0] O_TO   = 7'b0000001;
    localparam logic [6:0] O_TOFL = 7'b0000111;

    logic        clk_I     = 1'b0;
    logic        reset_n_I = 1'b0;
    int          checks    = 0;
    int          errors    = 0;
    logic [15:0] exp_stall = 16'd0;
    logic [7:0]  exp_flush = 8'd0;
    sb_t         sb_q[$];
    vec_t        tbl[9];
    logic [6:0]  outs;

    hazard_sequencer_if hif();

    hazard_sequencer #(.TIMEOUT(TO)) dut (
        .clk_I     (clk_I),
        .reset_n_I (reset_n_I),
        .hs        (hif)
    );

    always #5 clk_I = ~clk_I;

    assign outs = {hif.pcStall_O, hif.ifidStall_O, hif.idexStall_O, hif.exmemStall_O,
                   hif.ifidFlush_O, hif.idexFlush_O, hif.memwbBubble_O};

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic redir, input logic req,
                               input logic rdy);
        in_t v;
        v = '{rs1: rs1, rs2: rs2, u1: u1, u2: u2, rd: rd, mr: mr, redir: redir,
              req: req, rdy: rdy};
        return v;
    endfunction

    task automatic drive(input in_t v);
        hif.id_rs1_I      = v.rs1;
        hif.id_rs2_I      = v.rs2;
        hif.id_useRs1_I   = v.u1;
        hif.id_useRs2_I   = v.u2;
        hif.ex_rd_I       = v.rd;
        hif.ex_memRead_I  = v.mr;
        hif.ex_redirect_I = v.redir;
        hif.dmem_req_I    = v.req;
        hif.dmem_ready_I  = v.rdy;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic check_out();
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty act=0 exp=1");
        end else begin
            s = sb_q.pop_front();
            if (outs !== s.e) begin
                errors++;
                $display("FAIL %s outs=%b exp=%b", s.nm, outs, s.e);
            end
        end
    endtask

    // Called at posedge+1: drive, sample on the falling edge, then check counters after the next rise.
    task automatic step(input in_t v, input logic [6:0] e, input string nm);
        drive(v);
        sb_q.push_back('{e: e, nm: nm});
        #4;
        check_out();
        if (e[6] && (exp_stall != 16'hFFFF)) exp_stall = exp_stall + 16'd1;
        if (e[2] && (exp_flush != 8'hFF))    exp_flush = exp_flush + 8'd1;
        @(posedge clk_I);
        #1;
        chk({nm, "_stallCycles"}, hif.stallCycles_O, exp_stall);
        chk({nm, "_flushCount"}, {8'd0, hif.flushCount_O}, {8'd0, exp_flush});
    endtask

    task automatic apply_reset();
        reset_n_I = 1'b0;
        exp_stall = 16'd0;
        exp_flush = 8'd0;
        sb_q.delete();
        #1;
        chk("rst_stallCycles", hif.stallCycles_O, 16'd0);
        chk("rst_flushCount", {8'd0, hif.flushCount_O}, 16'd0);
        chk("rst_busErr", {15'd0, hif.busErr_O}, 16'd0);
        @(posedge clk_I);
        #1;
        reset_n_I = 1'b1;
    endtask

    in_t IDLE, LU5, FRZ, FRZ_R, FIRE_LU;

    initial begin
        IDLE    = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        LU5     = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        FRZ     = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        FRZ_R   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        FIRE_LU = mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);

        tbl[0] = '{i: IDLE, e: O_IDLE, nm: "idle"};
        tbl[1] = '{i: LU5, e: O_LU, nm: "lu_rs1"};
        tbl[2] = '{i: mk(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0), e: O_LU, nm: "lu_rs2"};
        tbl[3] = '{i: mk(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0), e: O_IDLE, nm: "rd_zero"};
        tbl[4] = '{i: mk(5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0), e: O_IDLE, nm: "no_use"};
        tbl[5] = '{i: mk(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0), e: O_IDLE, nm: "not_load"};
        tbl[6] = '{i: mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0), e: O_FL, nm: "redirect"};
        tbl[7] = '{i: mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0), e: O_FL, nm: "redir_lu"};
        tbl[8] = '{i: mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1), e: O_LU, nm: "mem_ready_lu"};

        drive(IDLE);
        @(posedge clk_I);
        #1;
        // Combinational controls respond while reset is held; counters do not move.
        drive(LU5);
        sb_q.push_back('{e: O_LU, nm: "lu_in_reset"});
        #4;
        check_out();
        @(posedge clk_I);
        #1;
        chk("reset_stallCycles", hif.stallCycles_O, 16'd0);
        chk("reset_flushCount", {8'd0, hif.flushCount_O}, 16'd0);
        chk("reset_busErr", {15'd0, hif.busErr_O}, 16'd0);
        drive(IDLE);
        reset_n_I = 1'b1;

        for (int k = 0; k < 9; k++) step(tbl[k].i, tbl[k].e, tbl[k].nm);

        // Memory wait of three cycles, then completion.
        repeat (3) step(FRZ, O_FRZ, "freeze");
        step(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1), O_IDLE, "release");
        step(IDLE, O_IDLE, "after_release");

        // Redirect during a wait is deferred to the release cycle, beating load-use there.
        step(FRZ_R, O_FRZ, "frz_redir");
        step(FRZ, O_FRZ, "frz_pend");
        step(mk(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1), O_FL, "release_flush");
        step(IDLE, O_IDLE, "pend_cleared");

        // Timeout: TIMEOUT freeze cycles, then the firing cycle releases with a bubble.
        repeat (TO) step(FRZ, O_FRZ, "to_freeze");
        chk("busErr_before_fire", {15'd0, hif.busErr_O}, 16'd0);
        step(FIRE_LU, O_TO, "timeout_fire");
        chk("busErr_set", {15'd0, hif.busErr_O}, 16'd1);
        step(FRZ_R, O_FRZ, "to2_frz_redir");
        repeat (TO - 1) step(FRZ, O_FRZ, "to2_freeze");
        step(FRZ, O_TOFL, "timeout_fire_flush");
        repeat (3) step(IDLE, O_IDLE, "post_timeout");
        chk("busErr_sticky", {15'd0, hif.busErr_O}, 16'd1);

        // Reset in the middle of a wait with a redirect pending.
        step(FRZ_R, O_FRZ, "mw_frz_redir");
        step(FRZ, O_FRZ, "mw_frz");
        drive(IDLE);
        apply_reset();
        step(IDLE, O_IDLE, "no_stale_flush");
        repeat (TO) step(FRZ, O_FRZ, "rst_to_freeze");
        step(FRZ, O_TO, "rst_timeout_fire");
        step(IDLE, O_IDLE, "rst_idle");

        // stallCycles saturation.
        drive(IDLE);
        apply_reset();
        drive(LU5);
        repeat (65534) @(posedge clk_I);
        #1;
        chk("stall_near_sat", hif.stallCycles_O, 16'hFFFE);
        @(posedge clk_I);
        #1;
        chk("stall_at_sat", hif.stallCycles_O, 16'hFFFF);
        repeat (5) @(posedge clk_I);
        #1;
        chk("stall_held_sat", hif.stallCycles_O, 16'hFFFF);

        // flushCount saturation.
        drive(IDLE);
        apply_reset();
        drive(tbl[6].i);
        repeat (254) @(posedge clk_I);
        #1;
        chk("flush_near_sat", {8'd0, hif.flushCount_O}, 16'h00FE);
        repeat (6) @(posedge clk_I);
        #1;
        chk("flush_held_sat", {8'd0, hif.flushCount_O}, 16'h00FF);
        chk("flush_no_stall", hif.stallCycles_O, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum consecutive data-memory wait cycles before the bus error is flagged; legal range 2..255.
REQ-002 clk_I  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n_I  input  1  asynchronous, active-low reset.
REQ-004 id_rs1_I, id_rs2_I  input  5 each  source registers of the instruction in ID.
REQ-005 id_useRs1_I, id_useRs2_I  input  1 each  ID instruction actually reads rs1 / rs2.
REQ-006 ex_rd_I  input  5  destination register of the instruction in EX.
REQ-007 ex_memRead_I  input  1  EX instruction is a load.
REQ-008 ex_redirect_I  input  1  EX resolved a taken branch or a jump; PC is redirected.
REQ-009 dmem_req_I  input  1  MEM stage holds a load or store.
REQ-010 dmem_ready_I  input  1  data memory completes the MEM access this cycle.
REQ-011 pcStall_O, ifidStall_O, idexStall_O, exmemStall_O  output  1 each  hold the PC or the named pipeline register.
REQ-012 ifidFlush_O, idexFlush_O  output  1 each  load a bubble into IF/ID or ID/EX.
REQ-013 memwbBubble_O  output  1  load a bubble into MEM/WB with write enables cleared.
REQ-014 busErr_O  output  1  sticky data-memory timeout flag.
REQ-015 stallCycles_O  output  16  saturating count of cycles with pcStall_O=1.
REQ-016 flushCount_O  output  8  saturating count of redirect flushes issued.

Function
REQ-017 The FSM SHALL have two states: RUN and MEM_WAIT.
REQ-018 memHold = dmem_req_I & ~dmem_ready_I & ~toFire, where toFire = (state==MEM_WAIT) & (waitCnt==TIMEOUT-1).
REQ-019 RUN->MEM_WAIT when memHold=1; MEM_WAIT->RUN when dmem_ready_I=1 or toFire=1; otherwise the state holds.
REQ-020 waitCnt (8-bit) SHALL clear in RUN and increment on each MEM_WAIT cycle.
REQ-021 While memHold=1: pcStall, ifidStall, idexStall and exmemStall SHALL be 1; memwbBubble SHALL be 1; both flushes SHALL be 0.
REQ-022 On toFire: busErr_O SHALL set and stay set until reset; memwbBubble SHALL be 1; the pipeline SHALL release that cycle with no stalls.
REQ-023 Redirect SHALL apply when ex_redirect_I=1 and memHold=0: ifidFlush=1 and idexFlush=1; flushCount increments by 1.
REQ-024 Register pendRedir SHALL set when ex_redirect_I=1 and memHold=1; it SHALL clear when the flush is issued.
REQ-025 In the release cycle, the flush SHALL issue if pendRedir=1 or ex_redirect_I=1; this counts as exactly one flush.
REQ-026 Load-use condition: ex_memRead_I & ex_rd_I!=0 & ((id_useRs1_I & ex_rd_I==id_rs1_I) | (id_useRs2_I & ex_rd_I==id_rs2_I)).
REQ-027 Load-use SHALL apply only when memHold=0 and no flush is issued. Response: pcStall=1, ifidStall=1, idexFlush=1, idexStall=0, exmemStall=0.
REQ-028 Priority SHALL be memHold > toFire/redirect flush > load-use; redirect and load-use together give the flush only.
REQ-029 All stall, flush and bubble outputs SHALL be combinational from current state, registers and inputs. Latency 0: same-cycle response.
REQ-030 stallCycles_O SHALL increment on each cycle with pcStall_O=1; it saturates at 16'hFFFF.
REQ-031 flushCount_O SHALL saturate at 8'hFF.

Reset
REQ-032 On reset_n_I=0: state=RUN, waitCnt=0, pendRedir=0, busErr_O=0, stallCycles_O=0, flushCount_O=0, asynchronously.
REQ-033 During reset, combinational outputs SHALL follow REQ-018..REQ-028 with the reset register values.
REQ-034 Reset mid-MEM_WAIT SHALL discard the pending flush and wait count; the first cycle after reset SHALL be RUN.

Verification
REQ-035 Load-use: ex_memRead=1, ex_rd=5, id_rs1=5, id_useRs1=1 for 1 cycle -> pcStall=ifidStall=idexFlush=1 that cycle; stallCycles 0->1.
REQ-036 Load with ex_rd=0 and matching id_rs1=0 -> no stall, no flush.
REQ-037 dmem_req=1, ready low 3 cycles then high -> 3 full-freeze cycles with memwbBubble=1; state MEM_WAIT->RUN; stallCycles=3.
REQ-038 ex_redirect=1 asserted during a 2-cycle wait -> no flush while frozen; one flush in the release cycle; flushCount=1.
REQ-039 TIMEOUT=4, dmem_req=1, ready never -> freeze cycles per REQ-018/REQ-019, then toFire cycle with release; busErr_O=1, persisting until reset.
REQ-040 Redirect and load-use in the same cycle -> flushes only, pcStall=0; also check stallCycles saturation at 16'hFFFF.
